bmp_pixel_proc: RTL and testbench
=================================

BMP_PIXEL_PROC -- requirements
Module: bmp_pixel_proc

Interface
REQ-001 SHALL have parameter DATA_BUS_SIZE, default 32, pixel-word width (32 or 64; multiple of 8).
REQ-002 SHALL have parameter OUT_DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-high (despite name); clock clk.
REQ-005 SHALL have port data_to_processor  in  DATA_BUS_SIZE  pixel word from arbiter.
REQ-006 SHALL have port valid  in  1  data_to_processor valid.
REQ-007 SHALL have port mode  in  2  operation: 01 threshold, 10 brightness; 00/11 illegal.
REQ-008 SHALL have port data_proc  in  8  operand (threshold level or brightness offset).
REQ-009 SHALL have port frame_words  in  24  pixel words in the frame (header excluded).
REQ-010 SHALL have port out_ready  in  1  master accepts data_out_pr.
REQ-011 SHALL have port in_ready  out  1  block accepts a word this cycle.
REQ-012 SHALL have port data_out_pr  out  DATA_BUS_SIZE  processed word (FIFO head).
REQ-013 SHALL have port vld_pr  out  1  data_out_pr valid.
REQ-014 SHALL have port busy  out  1  state != IDLE.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN.
REQ-017 Accept = valid && in_ready, sampled on rising edge.
REQ-018 in_ready SHALL be !fifo_full && (RUN || (IDLE && mode in {01,10} && frame_words != 0)); low in DRAIN.
REQ-019 IDLE, accept: latch mode, data_proc, frame_words; word count := 1; -> RUN (or -> DRAIN if frame_words == 1).
REQ-020 RUN, accept: count += 1; on count reaching latched frame_words -> DRAIN.
REQ-021 RUN SHALL use latched mode/data_proc; input mode/data_proc changes mid-frame are ignored.
REQ-022 Per byte, mode 01: out = (byte >= operand) ? 8'hFF : 8'h00.
REQ-023 Per byte, mode 10: out = min(byte + operand, 8'hFF), 9-bit sum, saturate.
REQ-024 All DATA_BUS_SIZE/8 bytes processed independently, same cycle; byte lanes preserved.
REQ-025 Processed word SHALL be written to output FIFO at the accept edge; vld_pr high the next cycle (latency 1).
REQ-026 vld_pr = !fifo_empty; data_out_pr = FIFO head, stable while vld_pr && !out_ready.
REQ-027 Pop = vld_pr && out_ready; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 Full: in_ready low, no push, no data loss; empty: vld_pr low, out_ready ignored.
REQ-029 DRAIN: when FIFO empty -> IDLE with frame_done = 1 for exactly one cycle.
REQ-030 valid while in_ready low SHALL be ignored; upstream holds the word.
REQ-031 IDLE with illegal mode or frame_words == 0: no accept, no state change.

Reset
REQ-032 rst_n high SHALL immediately force IDLE, count 0, FIFO empty, latched mode/operand 0.
REQ-033 During reset: vld_pr 0, frame_done 0, busy 0, data_out_pr 0, in_ready 0.
REQ-034 Reset mid-frame SHALL discard buffered words; first edge after release starts in IDLE.

Structure
REQ-035 Shared package bmp_pkg SHALL hold mode encodings (MODE_TH=01, MODE_BR=10), state enum, BMP_HDR_BYTES=54.
REQ-036 Output buffer SHALL be sub-module bmp_out_fifo (sync FIFO: push, pop, full, empty, head data, async active-high reset).
REQ-037 Byte operator SHALL be a generate loop over byte lanes, no sub-module.

Verification
REQ-038 Threshold: mode 01, operand 8'h80, frame_words 2, words 32'h7F80_01FF, 32'h0000_8181, out_ready 1 -> 32'h00FF_00FF, 32'h0000_FFFF, vld_pr one cycle after each accept, frame_done one cycle after last pop.
REQ-039 Brightness: mode 10, operand 8'h10, word 32'hF5_EF_00_7F -> 32'hFF_FF_10_8F.
REQ-040 Backpressure: OUT_DEPTH 4, out_ready 0, 6 words offered -> 4 accepted, in_ready 0; out_ready 1 -> remaining 2 accepted, 6 words out in order.
REQ-041 Mode change mid-frame: frame 3 words mode 10, mode driven 01 after word 1 -> all 3 words use brightness.
REQ-042 Illegal mode 11 or frame_words 0 in IDLE -> in_ready 0, busy 0, no output.
REQ-043 Reset after 2 of 5 words with FIFO non-empty -> vld_pr 0 immediately, new frame after release processed correctly.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP pixel processor: mode encodings, FSM states and
// the header size.
package bmp_pkg;

  localparam logic [1:0] MODE_TH = 2'b01;
  localparam logic [1:0] MODE_BR = 2'b10;

  localparam int unsigned BMP_HDR_BYTES = 54;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } bmp_state_e;

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_TH) || (m == MODE_BR);
  endfunction

endpackage

// File: rtl/bmp_out_fifo.sv
// Synchronous output FIFO with head-of-queue data and an async active-high reset.
module bmp_out_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the consumer only looks at it while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bmp_pixel_proc.sv
// Per-byte threshold / saturating-brightness processor for BMP pixel words with
// a frame-length FSM and a buffered output stream.
module bmp_pixel_proc
  import bmp_pkg::*;
#(
  parameter int unsigned DATA_BUS_SIZE = 32,
  parameter int unsigned OUT_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BUS_SIZE-1:0] data_to_processor,
  input  logic                     valid,
  input  logic [1:0]               mode,
  input  logic [7:0]               data_proc,
  input  logic [23:0]              frame_words,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic [DATA_BUS_SIZE-1:0] data_out_pr,
  output logic                     vld_pr,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned Lanes = DATA_BUS_SIZE / 8;

  bmp_state_e state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  op_q, op_d;
  logic [23:0] words_q, words_d;
  logic [23:0] count_q, count_d;

  logic                     fifo_full, fifo_empty, accept;
  logic [DATA_BUS_SIZE-1:0] fifo_head, proc_word;
  logic [1:0]               eff_mode;
  logic [7:0]               eff_op;

  // rst_n is active-high; hold in_ready low while it is asserted.
  assign in_ready = !rst_n && !fifo_full &&
                    ((state_q == StRun) ||
                     ((state_q == StIdle) && mode_legal(mode) && (frame_words != '0)));
  assign accept   = valid && in_ready;

  // The accepting word in IDLE uses the live inputs; later words use the latched copies.
  assign eff_mode = (state_q == StIdle) ? mode : mode_q;
  assign eff_op   = (state_q == StIdle) ? data_proc : op_q;

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    logic [7:0] b;
    logic [8:0] sum;
    assign b   = data_to_processor[8*i +: 8];
    assign sum = {1'b0, b} + {1'b0, eff_op};
    assign proc_word[8*i +: 8] = (eff_mode == MODE_TH) ? ((b >= eff_op) ? 8'hFF : 8'h00)
                                                       : (sum[8] ? 8'hFF : sum[7:0]);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    op_d    = op_q;
    words_d = words_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mode_d  = mode;
          op_d    = data_proc;
          words_d = frame_words;
          count_d = 24'd1;
          state_d = (frame_words == 24'd1) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          count_d = count_q + 24'd1;
          if ((count_q + 24'd1) == words_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      op_q    <= '0;
      words_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      words_q <= words_d;
      count_q <= count_d;
    end
  end

  bmp_out_fifo #(
    .Width(DATA_BUS_SIZE),
    .Depth(OUT_DEPTH)
  ) u_out_fifo (
    .clk  (clk),
    .rst  (rst_n),
    .push (accept),
    .pop  (vld_pr && out_ready),
    .wdata(proc_word),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign vld_pr      = !fifo_empty;
  assign data_out_pr = fifo_empty ? '0 : fifo_head;
  assign busy        = (state_q != StIdle);
  assign frame_done  = (state_q == StDrain) && fifo_empty;

endmodule

// File: tb/tb_bmp_pixel_proc.sv
// Scoreboard bench for bmp_pixel_proc: the driver queues expected words, a negedge
// monitor pops and compares them as the DUT presents output.
module tb_bmp_pixel_proc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_to_processor;
  logic        valid;
  logic [1:0]  mode;
  logic [7:0]  data_proc;
  logic [23:0] frame_words;
  logic        out_ready;
  logic        in_ready;
  logic [31:0] data_out_pr;
  logic        vld_pr;
  logic        busy;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned last_pop_cyc = 0;
  int unsigned done_cnt = 0;
  logic [31:0] exp_q [$];

  logic [31:0] bp_in  [6] = '{32'h00112233, 32'h44556677, 32'h8899AABB,
                              32'hCCDDEEFF, 32'h10203040, 32'hF0E0D0C0};
  logic [31:0] bp_exp [6] = '{32'h20314253, 32'h64758697, 32'hA8B9CADB,
                              32'hECFDFFFF, 32'h30405060, 32'hFFFFF0E0};

  bmp_pixel_proc #(
    .DATA_BUS_SIZE(32),
    .OUT_DEPTH    (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_to_processor(data_to_processor),
    .valid            (valid),
    .mode             (mode),
    .data_proc        (data_proc),
    .frame_words      (frame_words),
    .out_ready        (out_ready),
    .in_ready         (in_ready),
    .data_out_pr      (data_out_pr),
    .vld_pr           (vld_pr),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: a pop happens on the edge following a negedge where vld_pr && out_ready.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (vld_pr && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b0, data_out_pr, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_out_pr", data_out_pr == e, data_out_pr, e);
        end
        last_pop_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        check("frame_done_timing", cyc == last_pop_cyc + 1, cyc, last_pop_cyc + 1);
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] e);
    bit ok = 1'b0;
    data_to_processor = w;
    valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
        break;
      end
    end
    check("accept_timeout", ok, ok, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("vld_latency", vld_pr == 1'b1, vld_pr, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    data_to_processor = '0;
    valid = 1'b0;
    mode = 2'b01;
    data_proc = 8'h80;
    frame_words = 24'd2;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld_pr", vld_pr == 1'b0, vld_pr, 0);
    check("rst_in_ready", in_ready == 1'b0, in_ready, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_frame_done", frame_done == 1'b0, frame_done, 0);
    check("rst_data_out", data_out_pr == 32'h0, data_out_pr, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;

    // Threshold frame
    send(32'h7F80_01FF, 32'h00FF_00FF);
    send(32'h0000_8181, 32'h0000_FFFF);
    wait_idle("th_idle");
    check("th_done_cnt", done_cnt == 1, done_cnt, 1);

    // Brightness, single-word frame
    mode = 2'b10; data_proc = 8'h10; frame_words = 24'd1;
    send(32'hF5EF_007F, 32'hFFFF_108F);
    wait_idle("br_idle");
    check("br_done_cnt", done_cnt == 2, done_cnt, 2);

    // Backpressure: four words fill the FIFO, the fifth must stall
    mode = 2'b10; data_proc = 8'h20; frame_words = 24'd6; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(bp_in[i], bp_exp[i]);
    data_to_processor = bp_in[4];
    valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready == 1'b0, in_ready, 0);
    end
    check("bp_head", data_out_pr == bp_exp[0], data_out_pr, bp_exp[0]);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(bp_in[4], bp_exp[4]);
    send(bp_in[5], bp_exp[5]);
    wait_idle("bp_idle");
    check("bp_done_cnt", done_cnt == 3, done_cnt, 3);

    // Mode/operand changes mid-frame are ignored
    mode = 2'b10; data_proc = 8'h10; frame_words = 24'd3;
    send(32'h0102_0304, 32'h1112_1314);
    mode = 2'b01; data_proc = 8'hFF;
    send(32'hF0F1_F2F3, 32'hFFFF_FFFF);
    send(32'h8080_8080, 32'h9090_9090);
    wait_idle("mc_idle");
    check("mc_done_cnt", done_cnt == 4, done_cnt, 4);

    // Illegal mode, then zero-length frame
    mode = 2'b11; frame_words = 24'd3;
    data_to_processor = 32'h1234_5678;
    valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ill_mode_in_ready", in_ready == 1'b0, in_ready, 0);
      check("ill_mode_busy", busy == 1'b0, busy, 0);
      check("ill_mode_vld", vld_pr == 1'b0, vld_pr, 0);
    end
    @(posedge clk);
    #1 mode = 2'b01; frame_words = 24'd0;
    repeat (3) begin
      @(negedge clk);
      check("zero_fw_in_ready", in_ready == 1'b0, in_ready, 0);
      check("zero_fw_busy", busy == 1'b0, busy, 0);
      check("zero_fw_vld", vld_pr == 1'b0, vld_pr, 0);
    end
    @(posedge clk);
    #1 valid = 1'b0;
    check("ill_done_cnt", done_cnt == 4, done_cnt, 4);

    // Reset mid-frame with buffered words
    mode = 2'b01; data_proc = 8'h80; frame_words = 24'd5; out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(32'h0000_0000, 32'h0000_0000);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_vld_pr", vld_pr == 1'b0, vld_pr, 0);
    check("mid_rst_busy", busy == 1'b0, busy, 0);
    check("mid_rst_in_ready", in_ready == 1'b0, in_ready, 0);
    check("mid_rst_data_out", data_out_pr == 32'h0, data_out_pr, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    out_ready = 1'b1;
    mode = 2'b10; data_proc = 8'h01; frame_words = 24'd1;
    send(32'h0000_00FE, 32'h0101_01FF);
    wait_idle("post_rst_idle");
    check("post_rst_done_cnt", done_cnt == 5, done_cnt, 5);
    check("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
